// File: rtl/event_fifo_merger_if.sv
// Channel-side and output-side signals of the event FIFO merger.
// The merger uses the slave view; the producer/consumer side uses the master view.
interface event_fifo_merger_if #(
  parameter int NCH = 4,
  parameter int DW  = 32
);
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_eoe;
  logic [NCH-1:0]    ch_empty;
  logic [NCH-1:0]    ch_ack;
  logic [DW-1:0]     out_data;
  logic              out_empty;
  logic              out_ack;

  modport slave  (input  ch_data, ch_eoe, ch_empty, out_ack,
                  output ch_ack, out_data, out_empty);
  modport master (output ch_data, ch_eoe, ch_empty, out_ack,
                  input  ch_ack, out_data, out_empty);
endinterface

// File: rtl/event_fifo_merger.sv
// Round-robin, per-event-locked merger of NCH show-ahead event FIFOs into one framed word stream.
// Optional trailer word (EE, channel, word count) after each event: define EVT_TRAILER_EN.
module event_fifo_merger #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int CW  = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                enable,
  event_fifo_merger_if.slave  bus,
  output logic                busy,
  output logic [3:0]          cur_ch
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef EVT_TRAILER_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t           state_q, state_d;
  logic [CHW-1:0]   grant_q, grant_d;
  logic [CHW-1:0]   rr_q, rr_d;
  logic [CW-1:0]    cnt_q [NCH];
  logic [DW-1:0]    mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
`ifdef EVT_TRAILER_EN
  logic [15:0]      wcnt_q;
`endif

  logic [DW-1:0]    ch_word [NCH];
  logic             room, push, pop, ack, found;
  logic [DW-1:0]    push_word;
  logic [CHW-1:0]   pick;

  assign room = (count_q < 2'd2);
  assign pop  = bus.out_ack && (count_q != 2'd0);
  assign ack  = |bus.ch_ack;

  // Only the granted channel can see an ack, and only while its data phase has room.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_word[gi]    = bus.ch_data[gi*DW +: DW];
      assign bus.ch_ack[gi] = (state_q == S_DATA) && (grant_q == CHW'(gi)) &&
                              !bus.ch_empty[gi] && room;
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NCH;
      if (!found && !bus.ch_empty[idx]) begin
        found = 1'b1;
        pick  = CHW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    push      = 1'b0;
    push_word = '0;
    unique case (state_q)
      S_IDLE: if (enable && found) begin
        grant_d = pick;
        rr_d    = pick;
        state_d = S_HDR;
      end
      S_HDR: if (room) begin
        push            = 1'b1;
        push_word[31:0] = {8'hEB, 4'h0, 4'(grant_q), 16'(cnt_q[grant_q])};
        state_d         = S_DATA;
      end
      S_DATA: if (ack) begin
        push      = 1'b1;
        push_word = ch_word[grant_q];
        if (bus.ch_eoe[grant_q]) begin
`ifdef EVT_TRAILER_EN
          state_d = S_TRL;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef EVT_TRAILER_EN
      S_TRL: if (room) begin
        push            = 1'b1;
        push_word[31:0] = {8'hEE, 4'h0, 4'(grant_q), wcnt_q};
        state_d         = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= CHW'(NCH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Per-channel event counters advance on the EOE word, wrapping at 2^CW.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else if (ack && bus.ch_eoe[grant_q]) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + CW'(1);
    end
  end

`ifdef EVT_TRAILER_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wcnt_q <= '0;
    end else if (state_q == S_HDR && room) begin
      wcnt_q <= '0;
    end else if (ack && wcnt_q != 16'hFFFF) begin
      wcnt_q <= wcnt_q + 16'd1;
    end
  end
`endif

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign bus.out_empty = (count_q == 2'd0);
  assign bus.out_data  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
  assign busy          = (state_q != S_IDLE);
  assign cur_ch        = 4'(grant_q);
endmodule
